// File: rtl/bcd_time_sequencer_pkg.sv
// Shared definitions for the BCD time sequencer: FSM state encodings,
// the blank digit code for the segment decoder, and default field maxima.
package bcd_time_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_H = 3'd1,
        CONV_M = 3'd2,
        CONV_S = 3'd3,
        COMMIT = 3'd4
    } seq_state_e;

    // Digit code that the segment decoder renders as an unlit digit
    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam int unsigned HOURS_MAX_DEF  = 23;
    localparam int unsigned MINSEC_MAX_DEF = 59;

endpackage

// File: rtl/bcd_time_sequencer_bin_to_bcd.sv
// Combinational 6-bit binary to two-digit BCD converter ({tens, ones}).
// Covers 0..63 and has no clamping, so 63 becomes 8'h63.
module bin_to_bcd (
    input  logic [5:0] i_bin,
    output logic [7:0] o_bcd
);

    // ge_tens[k] is set when the input is at least k*10
    logic [6:1] ge_tens;
    logic [3:0] tens;
    logic [5:0] tens_x10;

    generate
        for (genvar gi = 1; gi <= 6; gi++) begin : g_ge_tens
            assign ge_tens[gi] = (i_bin >= 6'(gi * 10));
        end
    endgenerate

    // The flags are thermometer-coded, so the tens digit is their population count
    always_comb begin
        tens = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            tens = tens + {3'b000, ge_tens[i]};
        end
        case (tens)
            4'd1:    tens_x10 = 6'd10;
            4'd2:    tens_x10 = 6'd20;
            4'd3:    tens_x10 = 6'd30;
            4'd4:    tens_x10 = 6'd40;
            4'd5:    tens_x10 = 6'd50;
            4'd6:    tens_x10 = 6'd60;
            default: tens_x10 = 6'd0;
        endcase
        o_bcd = {tens, 4'(i_bin - tens_x10)};
    end

endmodule

// File: rtl/bcd_time_sequencer.sv
// Converts hours/minutes/seconds to BCD through one shared converter, one
// field per cycle, then commits all six digits at once so the display never
// shows a mix of old and new time.
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN blanks a zero hours tens digit.
module bcd_time_sequencer
    import bcd_time_sequencer_pkg::*;
#(
    parameter int unsigned HOURS_MAX  = HOURS_MAX_DEF,
    parameter int unsigned MINSEC_MAX = MINSEC_MAX_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_refresh_stb,
    input  logic [5:0] i_hours,
    input  logic [5:0] i_minutes,
    input  logic [5:0] i_seconds,
    output logic       o_busy,
    output logic       o_valid_stb,
    output logic       o_range_err,
    output logic [7:0] o_hours_bcd,
    output logic [7:0] o_minutes_bcd,
    output logic [7:0] o_seconds_bcd
);

    seq_state_e state_q, state_d;
    logic       pending_q, pending_d;

    logic [5:0] h_snap_q, m_snap_q, s_snap_q;
    logic [7:0] h_shadow_q, m_shadow_q, s_shadow_q;
    logic [7:0] hours_bcd_q, minutes_bcd_q, seconds_bcd_q;
    logic       valid_q, range_err_q;

    logic       start, cap_h, cap_m, cap_s, commit;
    logic [5:0] conv_bin;
    logic [7:0] conv_bcd;
    logic [7:0] hours_commit;
    logic       range_now;

    bin_to_bcd u_bin_to_bcd (
        .i_bin (conv_bin),
        .o_bcd (conv_bcd)
    );

    // State and pending-request registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next-state: walk the three fields then commit; strobes seen while busy coalesce into pending
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (i_refresh_stb || pending_q) begin
                    state_d   = CONV_H;
                    pending_d = 1'b0;
                end
            end
            CONV_H:  state_d = CONV_M;
            CONV_M:  state_d = CONV_S;
            CONV_S:  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && i_refresh_stb) begin
            pending_d = 1'b1;
        end
    end

    // Per-state controls: converter input mux and capture/commit enables
    always_comb begin
        o_busy   = (state_q != IDLE);
        start    = (state_q == IDLE) && (i_refresh_stb || pending_q);
        cap_h    = (state_q == CONV_H);
        cap_m    = (state_q == CONV_M);
        cap_s    = (state_q == CONV_S);
        commit   = (state_q == COMMIT);
        conv_bin = 6'd0;
        case (state_q)
            CONV_H:  conv_bin = h_snap_q;
            CONV_M:  conv_bin = m_snap_q;
            CONV_S:  conv_bin = s_snap_q;
            default: conv_bin = 6'd0;
        endcase
    end

    // Range flag and committed hours value, both taken from the snapshot of this sequence
    always_comb begin
        range_now = ({26'd0, h_snap_q} > HOURS_MAX) ||
                    ({26'd0, m_snap_q} > MINSEC_MAX) ||
                    ({26'd0, s_snap_q} > MINSEC_MAX);
        hours_commit = h_shadow_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (h_shadow_q[7:4] == 4'd0) begin
            hours_commit[7:4] = BCD_BLANK;
        end
`else
        // Digits pass through unchanged
`endif
    end

    // Snapshot, shadow capture and atomic output commit
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            h_snap_q      <= 6'd0;
            m_snap_q      <= 6'd0;
            s_snap_q      <= 6'd0;
            h_shadow_q    <= 8'd0;
            m_shadow_q    <= 8'd0;
            s_shadow_q    <= 8'd0;
            hours_bcd_q   <= 8'd0;
            minutes_bcd_q <= 8'd0;
            seconds_bcd_q <= 8'd0;
            valid_q       <= 1'b0;
            range_err_q   <= 1'b0;
        end else begin
            valid_q <= commit;
            if (start) begin
                h_snap_q <= i_hours;
                m_snap_q <= i_minutes;
                s_snap_q <= i_seconds;
            end
            if (cap_h) h_shadow_q <= conv_bcd;
            if (cap_m) m_shadow_q <= conv_bcd;
            if (cap_s) s_shadow_q <= conv_bcd;
            if (commit) begin
                hours_bcd_q   <= hours_commit;
                minutes_bcd_q <= m_shadow_q;
                seconds_bcd_q <= s_shadow_q;
                range_err_q   <= range_now;
            end
        end
    end

    assign o_valid_stb   = valid_q;
    assign o_range_err   = range_err_q;
    assign o_hours_bcd   = hours_bcd_q;
    assign o_minutes_bcd = minutes_bcd_q;
    assign o_seconds_bcd = seconds_bcd_q;

endmodule

// File: doc/bcd_time_sequencer.md
Name: bcd_time_sequencer

Overview:
- Shares one bin_to_bcd converter between three 6-bit time fields: hours, minutes and seconds.
- On each refresh strobe it snapshots the three fields and converts them one per cycle into shadow registers.
- It then commits all six BCD digits to the outputs at once, so the display driver never sees a mixed old/new time.
- Sits between the clock counter block and the 7-segment/display mux.

Parameters:
- HOURS_MAX, 23, largest legal hours value; above this sets the range flag.
- MINSEC_MAX, 59, largest legal minutes/seconds value; above this sets the range flag.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  synchronous active-low reset
- i_refresh_stb  input  1  single-cycle request to convert the current time
- i_hours  input  6  binary hours, 0..63
- i_minutes  input  6  binary minutes, 0..63
- i_seconds  input  6  binary seconds, 0..63
- o_busy  output  1  high while a conversion sequence is in progress
- o_valid_stb  output  1  one-cycle pulse on the commit cycle
- o_range_err  output  1  at least one committed field exceeded its maximum
- o_hours_bcd  output  8  {msb,lsb} BCD hours
- o_minutes_bcd  output  8  {msb,lsb} BCD minutes
- o_seconds_bcd  output  8  {msb,lsb} BCD seconds

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_reset_n.
- Reset values: all outputs 0, FSM in IDLE, pending flag cleared, shadow registers 0. Reset mid-sequence aborts with no commit.
- FSM states: IDLE, CONV_H, CONV_M, CONV_S, COMMIT.
  - IDLE: on i_refresh_stb (or pending flag set), snapshot all three inputs into holding registers, clear pending, go to CONV_H.
  - CONV_H, CONV_M, CONV_S: each state drives its snapshotted field into the shared bin_to_bcd (combinational) and latches {msb,lsb} into that field's shadow register at the end of the cycle.
  - COMMIT: copy shadows to outputs, pulse o_valid_stb, update o_range_err, return to IDLE.
- Latency: strobe sampled at edge N; outputs and o_valid_stb visible after edge N+4.
- Throughput: one sequence per 5 cycles.
- o_busy is high in CONV_H through COMMIT inclusive.
- Strobe while busy: sets the pending flag. Multiple strobes coalesce into one. The pending sequence starts the cycle after COMMIT and snapshots inputs at that time.
- A strobe coinciding with COMMIT counts as busy and sets pending.
- Range check: done on the snapshot.
  - o_range_err = (hours > HOURS_MAX) OR (minutes > MINSEC_MAX) OR (seconds > MINSEC_MAX).
  - It is replaced at every commit, not sticky across commits.
- Out-of-range values are still converted (e.g. 62 -> 0x62). No clamping.
- Inputs changing after the snapshot have no effect on the sequence in flight.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined: at commit, if the hours msb digit is 0, o_hours_bcd[7:4] = 4'hF (blank code for the segment decoder). Minutes and seconds are unaffected.
- Undefined: all digits output as converted. No blanking logic is synthesized.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=0, CONV_H=1, CONV_M=2, CONV_S=3, COMMIT=4; 3-bit)
  - BCD_BLANK = 4'hF
  - default maxima 23 and 59
- Single sub-module: the existing bin_to_bcd, instantiated once. Input mux and shadow-capture logic stay in this module.

Test Plan:
- Reset, then strobe with h=12, m=34, s=56 -> busy after 1 edge; valid_stb pulses at edge N+4; outputs 0x12/0x34/0x56; range_err=0.
- Strobe, then change inputs to 1/2/3 at edge N+1 -> committed outputs still 0x12/0x34/0x56. A strobe in CONV_M plus another in COMMIT -> exactly one further sequence, committing 0x01/0x02/0x03.
- h=24, m=60, s=63 -> outputs 0x24/0x60/0x63, range_err=1. The next sequence with 0/0/0 -> range_err=0, outputs 0x00/0x00/0x00.
- Boundaries 9/10/59 -> 0x09/0x10/0x59. With BCD_LEADING_ZERO_BLANK_EN, hours = 0xF9. h=0 -> 0xF0 with the macro, 0x00 without.
- Assert i_reset_n=0 during CONV_S -> next edge: outputs 0, busy=0, no valid_stb, pending cleared. A fresh strobe afterwards completes normally.
